mem_arbiter: RTL and testbench

Shares the single-port, synchronous-read data memory between two requesters: the core's MEM-stage load/store port and an auxiliary full-word port used by the program loader and debug path. For core stores it generates the byte enables and lane-aligned write data. For core loads it extracts the addressed byte or halfword and extends it. It applies fixed core priority, with a bounded-starvation guarantee for the auxiliary port.

---
 rtl/mem_arbiter_pkg.sv | 40 ++++
 rtl/mem_arbiter_load_extract.sv | 30 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter: RV32I load/store
// funct3 codes, response ownership tags and access legality checks.
package mem_arbiter_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_AUX  = 1'b1;

  typedef struct packed {
    logic       valid;
    logic       owner;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
  } rsp_t;

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == FNC_SB) || (funct3 == FNC_SH) || (funct3 == FNC_SW);
    return (funct3 == FNC_LB) || (funct3 == FNC_LH) || (funct3 == FNC_LW) ||
           (funct3 == FNC_LBU) || (funct3 == FNC_LHU);
  endfunction

  // Size is encoded in funct3[1:0] for both loads and stores.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extract.sv
// Combinational load lane select and extension; shared with the I/O read path.
module load_extract
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = word[8*offset +: 8];
  assign lane_half = offset[1] ? word[31:16] : word[15:0];

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    data = 32'h0;
    case (funct3)
      FNC_LB:  data = {{24{lane_byte[7]}}, lane_byte};
      FNC_LH:  data = {{16{lane_half[15]}}, lane_half};
      FNC_LW:  data = word;
      FNC_LBU: data = {24'h0, lane_byte};
      FNC_LHU: data = {16'h0, lane_half};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store port and
// the auxiliary full-word port, with fixed core priority and bounded aux starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  output logic                  core_rvalid,
  output logic [31:0]           core_rdata,
  output logic                  core_err,

  input  logic                  aux_req_valid,
  output logic                  aux_req_ready,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [31:0]           aux_wdata,
  output logic                  aux_rvalid,
  output logic [31:0]           aux_rdata,

  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] streak_q, streak_d;
  rsp_t       rsp_q, rsp_d;

  logic at_limit;
  logic core_grant, aux_grant;
  logic core_bad;
  logic [3:0]  store_we;
  logic [31:0] store_din;
  logic [31:0] load_data;
  logic        unused_addr;

  assign unused_addr = ^core_addr[31:ADDR_WIDTH+2];

  assign at_limit       = (streak_q == LIMIT);
  assign core_req_ready = !rst && !(aux_req_valid && at_limit);
  assign aux_req_ready  = !rst && (!core_req_valid || at_limit);
  assign core_grant     = core_req_valid && core_req_ready;
  assign aux_grant      = aux_req_valid && aux_req_ready;

  assign core_bad = !funct3_legal(core_we, core_funct3) ||
                    misaligned(core_funct3, core_addr[1:0]);

  always_comb begin
    store_we  = 4'b1111;
    store_din = core_wdata;
    case (core_funct3[1:0])
      2'b00: begin
        store_we  = 4'b0001 << core_addr[1:0];
        store_din = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        store_we  = 4'b0011 << {core_addr[1], 1'b0};
        store_din = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Memory port mux; bad core accesses are accepted but never touch memory.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = '0;
    mem_din  = 32'h0;
    if (core_grant && !core_bad) begin
      mem_en   = 1'b1;
      mem_addr = core_addr[ADDR_WIDTH+1:2];
      if (core_we) begin
        mem_we  = store_we;
        mem_din = store_din;
      end
    end else if (aux_grant) begin
      mem_en   = 1'b1;
      mem_we   = {4{aux_we}};
      mem_addr = aux_addr;
      mem_din  = aux_wdata;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (core_grant && aux_req_valid)
      streak_d = at_limit ? streak_q : streak_q + 4'd1;
    else if (aux_grant || !aux_req_valid)
      streak_d = 4'd0;
  end

  always_comb begin
    rsp_d = '0;
    if (core_grant) begin
      if (core_bad) begin
        rsp_d.err = 1'b1;
      end else if (!core_we) begin
        rsp_d.valid  = 1'b1;
        rsp_d.owner  = OWNER_CORE;
        rsp_d.funct3 = core_funct3;
        rsp_d.off    = core_addr[1:0];
      end
    end else if (aux_grant && !aux_we) begin
      rsp_d.valid = 1'b1;
      rsp_d.owner = OWNER_AUX;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control state needs reset; the payload fields are cleared too but carry no meaning without valid.
      streak_q <= 4'd0;
      rsp_q    <= '0;
    end else begin
      streak_q <= streak_d;
      rsp_q    <= rsp_d;
    end
  end

  load_extract u_load_extract (
    .funct3 (rsp_q.funct3),
    .offset (rsp_q.off),
    .word   (mem_dout),
    .data   (load_data)
  );

  // Responses are masked by rst so a read in flight when reset arrives is dropped.
  assign core_rvalid = !rst && rsp_q.valid && (rsp_q.owner == OWNER_CORE);
  assign aux_rvalid  = !rst && rsp_q.valid && (rsp_q.owner == OWNER_AUX);
  assign core_err    = !rst && rsp_q.err;
  assign core_rdata  = core_rvalid ? load_data : 32'h0;
  assign aux_rdata   = aux_rvalid ? mem_dout : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed plan steps followed by random
// traffic, checked against a byte-addressed reference model.
module tb_mem_arbiter;

  localparam int AW  = 14;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req_valid, core_req_ready, core_we;
  logic [2:0]    core_funct3;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic          core_rvalid, core_err;
  logic          aux_req_valid, aux_req_ready, aux_we, aux_rvalid;
  logic [AW-1:0] aux_addr;
  logic [31:0]   aux_wdata, aux_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_we(core_we), .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_err(core_err),
    .aux_req_valid(aux_req_valid), .aux_req_ready(aux_req_ready), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_rvalid(aux_rvalid),
    .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Single-port synchronous RAM, read-first.
  logic [31:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
      mem_dout <= ram[mem_addr];
    end
  end

  // Reference model state.
  logic [7:0]  bmem [int];
  int          streak_m;
  logic        pc_v, pa_v, pe;
  logic [31:0] pdata;
  int          n_vec, n_err;

  function automatic logic [7:0] rd_byte(input int a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    core_req_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b0;
    core_addr = 32'h0; core_wdata = 32'h0;
    aux_req_valid = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = 32'h0;
  endtask

  task automatic core(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
    core_req_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = d;
  endtask

  task automatic aux(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    aux_req_valid = 1'b1; aux_we = we; aux_addr = a; aux_wdata = d;
  endtask

  // Inputs are set at the negedge; check #1 later, then advance one cycle.
  task automatic tick();
    logic cg, ag, bad, legal, sgn;
    int size, off, wa, base;
    logic [3:0]  we_e;
    logic [31:0] din_e, rd, word;
    #1;
    if (rst) begin
      check("rst_ctl", {31'h0, core_req_ready | aux_req_ready | core_rvalid | aux_rvalid | core_err}, 32'h0);
      check("rst_mem_en_we", {27'h0, mem_en, mem_we}, 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_mem_din", mem_din, 32'h0);
      check("rst_core_rdata", core_rdata, 32'h0);
      check("rst_aux_rdata", aux_rdata, 32'h0);
      pc_v = 1'b0; pa_v = 1'b0; pe = 1'b0; streak_m = 0;
    end else begin
      check("core_rvalid", 32'(core_rvalid), 32'(pc_v));
      check("aux_rvalid", 32'(aux_rvalid), 32'(pa_v));
      check("core_err", 32'(core_err), 32'(pe));
      if (pc_v) check("core_rdata", core_rdata, pdata);
      if (pa_v) check("aux_rdata", aux_rdata, pdata);

      ag = aux_req_valid && (!core_req_valid || streak_m == LIM);
      cg = core_req_valid && !ag;
      check("core_ready", 32'(core_req_ready), 32'(!(aux_req_valid && streak_m == LIM)));
      check("aux_ready", 32'(aux_req_ready), 32'(!core_req_valid || streak_m == LIM));

      pc_v = 1'b0; pa_v = 1'b0; pe = 1'b0;
      if (cg) begin
        off  = int'(core_addr[1:0]);
        size = (core_funct3[1:0] == 2'd0) ? 1 : (core_funct3[1:0] == 2'd1) ? 2 : 4;
        legal = core_we ? (core_funct3 inside {3'd0, 3'd1, 3'd2})
                        : (core_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad  = !legal || (off % size != 0);
        wa   = int'(core_addr[AW+1:2]);
        base = wa * 4;
        if (bad) begin
          check("err_mem_en", 32'(mem_en), 32'h0);
          pe = 1'b1;
        end else begin
          check("core_mem_en", 32'(mem_en), 32'h1);
          check("core_mem_addr", 32'(mem_addr), 32'(wa));
          if (core_we) begin
            for (int i = 0; i < 4; i++) begin
              we_e[i] = (i >= off) && (i < off + size);
              din_e[8*i +: 8] = core_wdata[8*(i % size) +: 8];
            end
            check("core_mem_we", 32'(mem_we), 32'(we_e));
            check("core_mem_din", mem_din, din_e);
            for (int i = 0; i < 4; i++) if (we_e[i]) bmem[base + i] = din_e[8*i +: 8];
          end else begin
            check("load_mem_we", 32'(mem_we), 32'h0);
            rd = 32'h0;
            for (int i = 0; i < size; i++) rd[8*i +: 8] = rd_byte(base + off + i);
            sgn = !core_funct3[2] && size < 4 && rd[8*size-1];
            if (sgn) rd = rd | (32'hFFFF_FFFF << (8*size));
            pdata = rd; pc_v = 1'b1;
          end
        end
        streak_m = aux_req_valid ? streak_m + 1 : 0;
      end else if (ag) begin
        base = int'(aux_addr) * 4;
        check("aux_mem_en", 32'(mem_en), 32'h1);
        check("aux_mem_addr", 32'(mem_addr), 32'(aux_addr));
        check("aux_mem_we", 32'(mem_we), {28'h0, {4{aux_we}}});
        if (aux_we) begin
          check("aux_mem_din", mem_din, aux_wdata);
          for (int i = 0; i < 4; i++) bmem[base + i] = aux_wdata[8*i +: 8];
        end else begin
          for (int i = 0; i < 4; i++) word[8*i +: 8] = rd_byte(base + i);
          pdata = word; pa_v = 1'b1;
        end
        streak_m = 0;
      end else begin
        check("idle_mem_en", 32'(mem_en), 32'h0);
        streak_m = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; streak_m = 0;
    pc_v = 1'b0; pa_v = 1'b0; pe = 1'b0; pdata = 32'h0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Byte store then signed/unsigned byte loads.
    core(1'b1, 3'b000, 32'h103, 32'h0000_00A5); tick();
    core(1'b0, 3'b000, 32'h103, 32'h0);         tick();
    core(1'b0, 3'b100, 32'h103, 32'h0);         tick();
    idle(); tick();

    // Halfword store then signed/unsigned halfword loads.
    core(1'b1, 3'b001, 32'h202, 32'h0000_8001); tick();
    core(1'b0, 3'b001, 32'h202, 32'h0);         tick();
    core(1'b0, 3'b101, 32'h202, 32'h0);         tick();
    idle(); tick();

    // Misaligned word load, misaligned halfword store, illegal funct3.
    core(1'b0, 3'b010, 32'h005, 32'h0);         tick();
    core(1'b1, 3'b001, 32'h007, 32'h1234);      tick();
    core(1'b0, 3'b011, 32'h000, 32'h0);         tick();
    idle(); tick();

    // Seed aux-visible words, then hold both ports valid for starvation.
    aux(1'b1, 14'h010, 32'h1234_5678); tick();
    aux(1'b1, 14'h011, 32'hCAFE_F00D); tick();
    idle();
    for (int i = 0; i < 12; i++) begin
      core(1'b0, 3'b010, 32'h44, 32'h0);
      aux(1'b0, 14'h010, 32'h0);
      tick();
    end
    idle(); tick();

    // Back-to-back store then load of the same word.
    core(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF); tick();
    core(1'b0, 3'b010, 32'h40, 32'h0);         tick();
    idle(); tick();

    // Reset arriving while an aux read response is in flight.
    aux(1'b0, 14'h011, 32'h0); tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    core(1'b0, 3'b010, 32'h40, 32'h0); aux(1'b0, 14'h011, 32'h0); tick();
    idle(); tick();

    // Random traffic over a small address window with upper address noise.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom % 64) == 0;
      if ($urandom % 3 != 0) begin
        logic [2:0] f3;
        logic [31:0] a;
        f3 = 3'($urandom % 8);
        if ($urandom % 8 != 0) f3 = ($urandom % 2) ? 3'($urandom % 3) : (3'($urandom % 2) + 3'd4);
        a = ($urandom & 32'hFFFF_0000) | (32'($urandom % 16) << 2);
        if ($urandom % 2) a[1:0] = 2'($urandom % 4);
        core(1'($urandom % 2), f3, a, $urandom);
        if (core_we && f3[2]) core_funct3 = 3'($urandom % 3);
      end
      if ($urandom % 2) aux(1'($urandom % 2), 14'($urandom % 16), $urandom);
      tick();
    end
    rst = 1'b0; idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
